// File: rtl/cam_stream_gen.sv
// Camera-side stream source: OV7670-style pclk/href/vsync timing with a known byte pattern.
// Define CAM_GEN_LFSR_EN to replace the incrementing ramp with an 8-bit LFSR sequence.
module cam_stream_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_BLANK   = 144,
  parameter int unsigned BPP       = 2,
  parameter int unsigned V_SYNC    = 1,
  parameter int unsigned V_BACK    = 3,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned PCLK_HALF = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  output logic        pclk_o,
  output logic        href_o,
  output logic        vsync_o,
  output logic [7:0]  data_o,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_cnt_o
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StVsync  = 3'd1;
  localparam logic [2:0] StVback  = 3'd2;
  localparam logic [2:0] StActive = 3'd3;
  localparam logic [2:0] StVfront = 3'd4;

  localparam logic [15:0] DivLast    = 16'(PCLK_HALF - 1);
  localparam logic [10:0] HLast      = 11'((H_ACTIVE + H_BLANK) * BPP - 1);
  localparam logic [10:0] HActEnd    = 11'(H_ACTIVE * BPP);
  localparam logic [9:0]  VSyncLast  = 10'(V_SYNC - 1);
  localparam logic [9:0]  VBackLast  = 10'(V_BACK - 1);
  localparam logic [9:0]  VActLast   = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  VFrontLast = 10'(V_FRONT - 1);

  logic [15:0] div_q, div_d;
  logic        pclk_q, pclk_d;
  logic [2:0]  state_q, state_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        href_q, href_d;
  logic        vsync_q, vsync_d;
  logic [7:0]  data_q, data_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        div_tc;
  logic        fall_tick;
  logic        line_end;
  logic [9:0]  lines_last;
  logic [7:0]  data_seed;
  logic [7:0]  data_step;

`ifdef CAM_GEN_LFSR_EN
  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  assign data_seed = 8'h01;
  assign data_step = {data_q[6:0], data_q[7] ^ data_q[5] ^ data_q[4] ^ data_q[3]};
`else
  assign data_seed = 8'h00;
  assign data_step = data_q + 8'd1;
`endif

  assign div_tc    = (div_q == DivLast);
  assign fall_tick = div_tc && pclk_q;
  assign line_end  = (hcnt_q == HLast);

  always_comb begin
    lines_last = VSyncLast;
    unique case (state_q)
      StVback:  lines_last = VBackLast;
      StActive: lines_last = VActLast;
      StVfront: lines_last = VFrontLast;
      default:  lines_last = VSyncLast;
    endcase
  end

  always_comb begin
    div_d   = div_tc ? 16'd0 : div_q + 16'd1;
    pclk_d  = div_tc ? ~pclk_q : pclk_q;
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    href_d  = href_q;
    vsync_d = vsync_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    fcnt_d  = fcnt_q;

    if (fall_tick) begin
      if (state_q == StIdle) begin
        if (en_i) begin
          state_d = StVsync;
          busy_d  = 1'b1;
          hcnt_d  = 11'd0;
          vcnt_d  = 10'd0;
        end
      end else begin
        hcnt_d = line_end ? 11'd0 : hcnt_q + 11'd1;
        if (line_end) begin
          vcnt_d = vcnt_q + 10'd1;
          if (vcnt_q == lines_last) begin
            vcnt_d = 10'd0;
            unique case (state_q)
              StVsync:  state_d = StVback;
              StVback:  state_d = StActive;
              StActive: state_d = StVfront;
              default: begin
                // End of frame: en is only looked at here, so a mid-frame drop never truncates.
                done_d = 1'b1;
                fcnt_d = fcnt_q + 16'd1;
                if (en_i) begin
                  state_d = StVsync;
                end else begin
                  state_d = StIdle;
                  busy_d  = 1'b0;
                end
              end
            endcase
          end
        end
      end
      vsync_d = (state_d == StVsync);
      href_d  = (state_d == StActive) && (hcnt_d < HActEnd);
      if (!href_d) begin
        data_d = 8'h00;
      end else if (!href_q) begin
        data_d = data_seed;
      end else begin
        data_d = data_step;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= 16'd0;
      pclk_q  <= 1'b1;
      state_q <= StIdle;
      hcnt_q  <= 11'd0;
      vcnt_q  <= 10'd0;
      href_q  <= 1'b0;
      vsync_q <= 1'b0;
      data_q  <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= 16'd0;
    end else begin
      div_q   <= div_d;
      pclk_q  <= pclk_d;
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      href_q  <= href_d;
      vsync_q <= vsync_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pclk_o       = pclk_q;
  assign href_o       = href_q;
  assign vsync_o      = vsync_q;
  assign data_o       = data_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;
  assign frame_cnt_o  = fcnt_q;

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen: frame-position model checked every clk, plus directed timing checks.
// A second instance with full-width lines exercises the in-line data wrap and line length.
module tb_cam_stream_gen;

  localparam int unsigned HA = 4, HB = 2, BP = 2, VS = 1, VB = 1, VA = 3, VF = 1, PH = 2;
  localparam int unsigned LINE  = (HA + HB) * BP;
  localparam int unsigned FRAME = (VS + VB + VA + VF) * LINE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic pclk, href, vsync, busy, fdone;
  logic [7:0]  data;
  logic [15:0] fcnt;

  logic rst2 = 1'b1;
  logic en2  = 1'b0;
  logic pclk2, href2, vsync2, busy2, fdone2;
  logic [7:0]  data2;
  logic [15:0] fcnt2;

  always #5 clk = ~clk;

  cam_stream_gen #(
    .H_ACTIVE(HA), .H_BLANK(HB), .BPP(BP), .V_SYNC(VS), .V_BACK(VB),
    .V_ACTIVE(VA), .V_FRONT(VF), .PCLK_HALF(PH)
  ) u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .pclk_o(pclk), .href_o(href), .vsync_o(vsync),
    .data_o(data), .busy_o(busy), .frame_done_o(fdone), .frame_cnt_o(fcnt)
  );

  cam_stream_gen #(
    .H_ACTIVE(640), .H_BLANK(144), .BPP(2), .V_SYNC(1), .V_BACK(1),
    .V_ACTIVE(2), .V_FRONT(1), .PCLK_HALF(2)
  ) u_dut_wide (
    .clk_i(clk), .rst_i(rst2), .en_i(en2), .pclk_o(pclk2), .href_o(href2), .vsync_o(vsync2),
    .data_o(data2), .busy_o(busy2), .frame_done_o(fdone2), .frame_cnt_o(fcnt2)
  );

  // Expected byte at offset h inside an href pulse.
  function automatic logic [7:0] exp_byte(int unsigned h);
    logic [7:0] v;
`ifdef CAM_GEN_LFSR_EN
    v = 8'h01;
    for (int i = 0; i < int'(h); i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
`else
    v = 8'(h % 256);
`endif
    return v;
  endfunction

  // Model: clk count since reset, running flag, pclk-period index within the frame.
  int unsigned m_c = 0, m_p = 0, m_fc = 0;
  bit m_run = 1'b0, m_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_c <= 0; m_p <= 0; m_fc <= 0; m_run <= 1'b0; m_done <= 1'b0;
    end else begin
      m_c    <= m_c + 1;
      m_done <= 1'b0;
      if (((m_c + 1) % (2 * PH)) == PH) begin
        if (!m_run) begin
          if (en) begin m_run <= 1'b1; m_p <= 0; end
        end else if (m_p == FRAME - 1) begin
          m_done <= 1'b1;
          m_fc   <= (m_fc + 1) % 65536;
          if (en) m_p <= 0;
          else m_run <= 1'b0;
        end else begin
          m_p <= m_p + 1;
        end
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor state (main DUT, sampled once per pclk rise).
  int cyc = 0, last_rise_cyc = -1, pclk_period = 0, idx = 0;
  int vs_high = 0, vs_starts = 0, vs_last = 0, busy_rises = 0, done_cnt = 0;
  int cur_len = 0, gap_len = 0;
  bit gap_armed = 1'b0, href_p = 1'b0, vs_p = 1'b0, pclk_p = 1'b1;
  int len_q[$], gap_q[$], vs_iv_q[$];
  logic [7:0] data_q[$];

  // Monitor state (wide DUT).
  int w_idx = 0, w_cur = 0, w_rises = 0, w_rise_last = 0, w_period = 0, w_len = 0;
  bit w_href_p = 1'b0, w_pclk_p = 1'b1;
  logic [7:0] w_b0, w_b255, w_b256, w_b1279;

  task automatic compare_model();
    int unsigned line, h;
    logic e_vs, e_hr;
    logic [7:0] e_d;
    line = m_p / LINE;
    h    = m_p % LINE;
    e_vs = m_run && (line < VS);
    e_hr = m_run && (line >= VS + VB) && (line < VS + VB + VA) && (h < HA * BP);
    e_d  = e_hr ? exp_byte(h) : 8'h00;
    check("m_pclk", {31'd0, pclk}, {31'd0, ((m_c / PH) % 2) == 0});
    check("m_vsync", {31'd0, vsync}, {31'd0, e_vs});
    check("m_href", {31'd0, href}, {31'd0, e_hr});
    check("m_data", {24'd0, data}, {24'd0, e_d});
    check("m_busy", {31'd0, busy}, {31'd0, m_run});
    check("m_done", {31'd0, fdone}, {31'd0, m_done});
    check("m_fcnt", {16'd0, fcnt}, m_fc);
  endtask

  task automatic monitor();
    cyc++;
    if (rst) begin
      vs_high = 0; vs_starts = 0; busy_rises = 0; done_cnt = 0; cur_len = 0; gap_len = 0;
      gap_armed = 1'b0; href_p = 1'b0; vs_p = 1'b0;
      len_q.delete(); gap_q.delete(); vs_iv_q.delete(); data_q.delete();
    end else begin
      if (fdone) done_cnt++;
      if (pclk && !pclk_p) begin
        if (last_rise_cyc >= 0) pclk_period = cyc - last_rise_cyc;
        last_rise_cyc = cyc;
        if (busy) busy_rises++;
        if (vsync) begin
          vs_high++;
          gap_armed = 1'b0;
          if (!vs_p) begin
            vs_starts++;
            if (vs_starts > 1) vs_iv_q.push_back(idx - vs_last);
            vs_last = idx;
          end
        end
        if (href) begin
          if (!href_p && gap_armed) gap_q.push_back(gap_len);
          cur_len++;
          data_q.push_back(data);
        end else begin
          if (href_p) begin
            len_q.push_back(cur_len); cur_len = 0; gap_armed = 1'b1; gap_len = 0;
          end
          if (gap_armed) gap_len++;
        end
        href_p = href;
        vs_p   = vsync;
        idx++;
      end
    end
    pclk_p = pclk;
    if (pclk2 && !w_pclk_p && !rst2) begin
      if (href2) begin
        if (!w_href_p) begin
          w_rises++;
          if (w_rises > 1) w_period = w_idx - w_rise_last;
          w_rise_last = w_idx;
          w_cur = 0;
        end
        if (w_rises == 1) begin
          if (w_cur == 0) w_b0 = data2;
          if (w_cur == 255) w_b255 = data2;
          if (w_cur == 256) w_b256 = data2;
          if (w_cur == 1279) w_b1279 = data2;
        end
        w_cur++;
      end else if (w_href_p && w_rises == 1) begin
        w_len = w_cur;
      end
      w_href_p = href2;
      w_idx++;
    end
    w_pclk_p = pclk2;
  endtask

  logic [7:0] line_lit[8];
  int base_cnt;

  initial begin
`ifdef CAM_GEN_LFSR_EN
    line_lit = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
`else
    line_lit = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
`endif
    fork
      forever begin
        @(negedge clk);
        if (chk_on) compare_model();
        monitor();
      end
    join_none

    // 1: reset
    @(posedge clk);
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_pclk", {31'd0, pclk}, 32'd1);
    check("rst_href", {31'd0, href}, 32'd0);
    check("rst_vsync", {31'd0, vsync}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fcnt", {16'd0, fcnt}, 32'd0);
    rst  = 1'b0;
    rst2 = 1'b0;
    en2  = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("t1_pclk_period", pclk_period, 32'd4);
    check("t1_vsync_idle", vs_high, 32'd0);

    // 2: one frame
    en = 1'b1;
    for (int k = 0; k < 20 && !busy; k++) @(negedge clk);
    check("t2_busy_rise", {31'd0, busy}, 32'd1);
    en = 1'b0;
    for (int k = 0; k < 400 && !fdone; k++) @(negedge clk);
    check("t2_done_seen", {31'd0, fdone}, 32'd1);
    repeat (8) @(negedge clk);
    #1;
    check("t2_vsync_pclk", vs_high, 32'd12);
    check("t2_href_pulses", len_q.size(), 32'd3);
    foreach (len_q[i]) check("t2_href_len", len_q[i], 32'd8);
    check("t2_gaps", gap_q.size(), 32'd2);
    foreach (gap_q[i]) check("t2_gap_len", gap_q[i], 32'd4);
    check("t2_bytes", data_q.size(), 32'd24);
    foreach (data_q[i]) check("t2_byte", {24'd0, data_q[i]}, {24'd0, line_lit[i % 8]});
    check("t2_frame_pclk", busy_rises, 32'd72);
    check("t2_done_cnt", done_cnt, 32'd1);
    check("t2_fcnt", {16'd0, fcnt}, 32'd1);
    check("t2_busy_end", {31'd0, busy}, 32'd0);

    // 3: back-to-back frames
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    for (int k = 0; k < 1000 && fcnt != 16'd2; k++) @(negedge clk);
    check("t3_two_frames", {16'd0, fcnt}, 32'd2);
    en = 1'b0;
    for (int k = 0; k < 400 && busy; k++) @(negedge clk);
    #1;
    check("t3_fcnt", {16'd0, fcnt}, 32'd3);
    check("t3_vs_starts", vs_starts, 32'd3);
    check("t3_intervals", vs_iv_q.size(), 32'd2);
    foreach (vs_iv_q[i]) check("t3_vs_period", vs_iv_q[i], 32'd72);
    check("t3_busy_pclk", busy_rises, 32'd216);
    check("t3_done_cnt", done_cnt, 32'd3);

    // 4: en drop mid-frame, then reset mid-frame
    base_cnt = int'(fcnt);
    en = 1'b1;
    for (int k = 0; k < 200 && !href; k++) @(negedge clk);
    check("t4_in_active", {31'd0, href}, 32'd1);
    en = 1'b0;
    for (int k = 0; k < 400 && !fdone; k++) @(negedge clk);
    check("t4_fcnt_inc", {16'd0, fcnt}, base_cnt + 1);
    @(negedge clk);
    check("t4_idle", {31'd0, busy}, 32'd0);
    en = 1'b1;
    for (int k = 0; k < 200 && !href; k++) @(negedge clk);
    check("t4_in_active2", {31'd0, href}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("t4_rst_pclk", {31'd0, pclk}, 32'd1);
    check("t4_rst_href", {31'd0, href}, 32'd0);
    check("t4_rst_vsync", {31'd0, vsync}, 32'd0);
    check("t4_rst_data", {24'd0, data}, 32'd0);
    check("t4_rst_busy", {31'd0, busy}, 32'd0);
    check("t4_rst_fcnt", {16'd0, fcnt}, 32'd0);
    rst = 1'b0;
    en  = 1'b0;

    // 5: full-width lines on the second instance
    for (int k = 0; k < 40000 && w_rises < 2; k++) @(negedge clk);
    #1;
    check("t5_second_line", w_rises, 32'd2);
    check("t5_href_len", w_len, 32'd1280);
    check("t5_line_pclk", w_period, 32'd1568);
    check("t5_byte0", {24'd0, w_b0}, {24'd0, exp_byte(0)});
    check("t5_byte255", {24'd0, w_b255}, {24'd0, exp_byte(255)});
    check("t5_byte256", {24'd0, w_b256}, {24'd0, exp_byte(256)});
    check("t5_byte1279", {24'd0, w_b1279}, {24'd0, exp_byte(1279)});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
